// File: rtl/ram16_fifo.sv
// ram16x16s: 16-word by 16-bit single-port storage for the FIFO body.
// Latency: write lands on the rising edge; read is combinational from addr.
// Backpressure: none; the caller decides when to write.
module ram16x16s (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [15:0] d,
    output logic [15:0] o
);

    logic [15:0] mem [16];

    // Synchronous write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
        end
    end

    assign o = mem[addr];

endmodule

// ram16_fifo: 17-deep 16-bit FIFO, 16 words in RAM plus a registered head word.
// Latency: a push into an empty FIFO is visible on dout the next cycle.
// Backpressure: full blocks pushes; pushes while full or pops while empty set sticky err.
module ram16_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] din,
    output logic        full,
    input  logic        pop,
    output logic [15:0] dout,
    output logic        empty,
    output logic [4:0]  count,
    output logic        err
);

    logic [3:0]  wptr;
    logic [3:0]  rptr;
    logic [4:0]  ram_cnt;
    logic        ovalid;
    logic [15:0] ram_o;

    logic push_ok;
    logic pop_ok;
    logic head_free;
    logic bypass;
    logic wr;
    logic refill;

    // Classify the cycle: bypass straight to the head register, write to RAM,
    // or refill the head register from RAM. A write owns the single RAM port,
    // so a pop that coincides with a write leaves a one-cycle bubble.
    always_comb begin
        push_ok   = push & ~full;
        pop_ok    = pop & ovalid;
        head_free = ~ovalid | pop_ok;
        bypass    = push_ok & (ram_cnt == 5'd0) & head_free;
        wr        = push_ok & ~bypass;
        refill    = ~wr & (ram_cnt != 5'd0) & head_free;
    end

    ram16x16s u_ram (
        .clk  (clk),
        .we   (wr),
        .addr (wr ? wptr : rptr),
        .d    (din),
        .o    (ram_o)
    );

    // Pointer, occupancy, head register and error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= 4'd0;
            rptr    <= 4'd0;
            ram_cnt <= 5'd0;
            ovalid  <= 1'b0;
            dout    <= 16'h0000;
            err     <= 1'b0;
        end else begin
            if ((push & full) | (pop & ~ovalid)) begin
                err <= 1'b1;
            end

            if (bypass) begin
                dout   <= din;
                ovalid <= 1'b1;
            end else if (refill) begin
                dout   <= ram_o;
                ovalid <= 1'b1;
                rptr   <= rptr + 4'd1;
            end else if (pop_ok) begin
                ovalid <= 1'b0;
            end

            if (wr) begin
                wptr <= wptr + 4'd1;
            end

            if (wr) begin
                ram_cnt <= ram_cnt + 5'd1;
            end else if (refill) begin
                ram_cnt <= ram_cnt - 5'd1;
            end
        end
    end

    assign full  = (ram_cnt == 5'd16);
    assign empty = ~ovalid;
    assign count = ram_cnt + {4'd0, ovalid};

endmodule

// File: tb/tb_ram16_fifo.sv
// Bench for ram16_fifo: directed scenarios plus random traffic against a queue model.
// Latency: outputs are sampled 1ns after each rising edge.
// Backpressure: the model decides acceptance from its own occupancy.
module tb_ram16_fifo;

    logic        clk;
    logic        rst;
    logic        push;
    logic [15:0] din;
    logic        full;
    logic        pop;
    logic [15:0] dout;
    logic        empty;
    logic [4:0]  count;
    logic        err;

    int checks = 0;
    int passed = 0;

    // Reference model: every held word in arrival order; q[0] is the head
    // word whenever m_ov is set, the rest live in the RAM.
    logic [15:0] q[$];
    logic        m_ov   = 1'b0;
    logic [15:0] m_dout = 16'h0000;
    logic        m_err  = 1'b0;

    ram16_fifo dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .full  (full),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .count (count),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic p, input logic [15:0] d, input logic po, input logic r);
        int ramc;
        bit pok, qok, byp, wr, rf;
        push = p;
        din  = d;
        pop  = po;
        rst  = r;
        if (r) begin
            q.delete();
            m_ov   = 1'b0;
            m_dout = 16'h0000;
            m_err  = 1'b0;
        end else begin
            ramc = q.size() - int'(m_ov);
            pok  = p && (ramc != 16);
            qok  = po && m_ov;
            byp  = pok && (ramc == 0) && (!m_ov || qok);
            wr   = pok && !byp;
            rf   = !wr && (ramc != 0) && (!m_ov || qok);
            if ((p && ramc == 16) || (po && !m_ov)) m_err = 1'b1;
            if (qok) void'(q.pop_front());
            if (pok) q.push_back(d);
            if (byp || rf) begin
                m_ov   = 1'b1;
                m_dout = q[0];
            end else if (qok) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("dout",  32'(dout),  32'(m_dout));
        chk("empty", 32'(empty), 32'(!m_ov));
        chk("count", 32'(count), 32'(q.size()));
        chk("full",  32'(full),  32'((q.size() - int'(m_ov)) == 16));
        chk("err",   32'(err),   32'(m_err));
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] rp;
        push = 1'b0;
        din  = 16'h0000;
        pop  = 1'b0;
        rst  = 1'b1;

        // Reset state.
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout",  32'(dout),  32'h0);

        // Single word into an empty FIFO bypasses the RAM.
        step(1'b1, 16'hA5A5, 1'b0, 1'b0);
        chk("byp_dout",  32'(dout),     32'hA5A5);
        chk("byp_empty", 32'(empty),    32'd0);
        chk("byp_count", 32'(count),    32'd1);
        chk("byp_wptr",  32'(dut.wptr), 32'd0);

        // Fill to 17 then overflow.
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd17);
        chk("fill_err",   32'(err),   32'd0);
        chk("fill_dout",  32'(dout),  32'h0001);
        step(1'b1, 16'h0012, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd17);
        chk("ovf_err",   32'(err),   32'd1);

        // Drain all 17 then underflow.
        for (int i = 1; i <= 17; i++) begin
            chk("drain_head", 32'(dout), 32'(i));
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        rp = dut.rptr;
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("udf_err",  32'(err),      32'd1);
        chk("udf_rptr", 32'(dut.rptr), 32'(rp));

        // Bubble: pop coinciding with a RAM write.
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h0101, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 1'b0, 1'b0);
        step(1'b1, 16'h0303, 1'b0, 1'b0);
        step(1'b1, 16'h00FF, 1'b1, 1'b0);
        chk("bub_empty", 32'(empty), 32'd1);
        chk("bub_count", 32'(count), 32'd3);
        idle();
        chk("bub_refill_empty", 32'(empty), 32'd0);
        chk("bub_refill_dout",  32'(dout),  32'h0202);

        // Wrap-around: prefill so traffic goes through the RAM, then alternate.
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        while (!empty && checks < 5000) step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("wrap_err",   32'(err),   32'd0);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Reset mid-stream with a simultaneous push.
        for (int i = 0; i < 9; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
        chk("mid_count9", 32'(count), 32'd9);
        step(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_dout",  32'(dout),  32'h0);
        chk("mid_err",   32'(err),   32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 16'($urandom),
                 ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 127) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
